// File: rtl/seq_bin_to_7seg.sv
// Sequential binary-to-decimal 7-segment driver.
// Converts a DATA_W-bit value (optionally two's complement) into DIGITS BCD
// digits with a shift-add-3 loop, one shift per clock. It then registers the
// segment patterns, with optional leading-zero blanking and a minus sign.
module seq_bin_to_7seg #(
  parameter int DATA_W     = 8,
  parameter int DIGITS     = 3,
  parameter int SIGNED_EN  = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  signed_i,
  input  logic                  blank_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic                  neg_o
);

  // Decimal digits needed for the largest magnitude: ceil(DATA_W*log10(2)),
  // plus one position for the minus sign when signed input is supported.
  localparam int MIN_DIGITS = (DATA_W * 30103 + 99999) / 100000 + ((SIGNED_EN != 0) ? 1 : 0);
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam logic [7*DIGITS-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DATA_W < 2 || DIGITS < MIN_DIGITS) begin : g_param_check
    $error("seq_bin_to_7seg: DIGITS=%0d too small for DATA_W=%0d (need %0d)",
           DIGITS, DATA_W, MIN_DIGITS);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   mag_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                neg_reg;
  logic                blank_reg;

  logic [4*DIGITS-1:0] bcd_next;
  logic [DATA_W-1:0]   mag_next;
  logic [DIGITS-1:0]   carry;
  logic [7*DIGITS-1:0] seg_next;
  logic                neg_in;
  logic [DATA_W-1:0]   mag_in;

  // Segment pattern for one decimal digit, active-high, bit order {g..a}.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    case (d)
      4'd0:    digit_pattern = 7'h3F;
      4'd1:    digit_pattern = 7'h06;
      4'd2:    digit_pattern = 7'h5B;
      4'd3:    digit_pattern = 7'h4F;
      4'd4:    digit_pattern = 7'h66;
      4'd5:    digit_pattern = 7'h6D;
      4'd6:    digit_pattern = 7'h7D;
      4'd7:    digit_pattern = 7'h07;
      4'd8:    digit_pattern = 7'h7F;
      4'd9:    digit_pattern = 7'h6F;
      default: digit_pattern = 7'h00;
    endcase
  endfunction

  // Negative inputs are converted as their magnitude; the most negative value
  // maps to 2^(DATA_W-1), which still fits in DATA_W unsigned bits.
  assign neg_in = (SIGNED_EN != 0) && signed_i && data_i[DATA_W-1];
  assign mag_in = neg_in ? (~data_i + DATA_W'(1)) : data_i;

  // One shift step: the binary MSB enters the units digit.
  // Each digit carries its adjusted MSB into the next digit up.
  assign carry[0] = mag_reg[DATA_W-1];
  assign mag_next = {mag_reg[DATA_W-2:0], 1'b0};

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] cur;
    logic [6:0] lit;
    logic       blank_digit;
    logic       is_minus;

    assign cur = bcd_reg[4*gi +: 4];

    // Add-3 correction and shift for this digit. The top digit cannot
    // overflow because DIGITS covers the full magnitude range.
    if (gi < DIGITS - 1) begin : g_low
      logic [3:0] adj;
      assign adj                 = (cur >= 4'd5) ? cur + 4'd3 : cur;
      assign bcd_next[4*gi +: 4] = {adj[2:0], carry[gi]};
      assign carry[gi+1]         = adj[3];
    end else begin : g_top
      assign bcd_next[4*gi +: 4] = {3'((cur >= 4'd5) ? cur + 4'd3 : cur), carry[gi]};
    end

    // A digit blanks when it and every digit above it are zero; units never blank.
    if (gi == 0) begin : g_units
      assign blank_digit = 1'b0;
    end else begin : g_upper
      assign blank_digit = blank_reg && ~|bcd_next[4*DIGITS-1:4*gi];
    end

    // The leftmost position carries the sign and is always zero in BCD when negative.
    if (gi == DIGITS - 1) begin : g_sign
      assign is_minus = neg_reg;
    end else begin : g_nosign
      assign is_minus = 1'b0;
    end

    assign lit = is_minus    ? 7'h40 :
                 blank_digit ? 7'h00 : digit_pattern(bcd_next[4*gi +: 4]);
    assign seg_next[7*gi +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  // Control FSM, shift datapath and registered display outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      mag_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      blank_reg <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      bcd_o     <= '0;
      seg_o     <= SEG_OFF;
      neg_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            mag_reg   <= mag_in;
            neg_reg   <= neg_in;
            blank_reg <= blank_i;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_o    <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          mag_reg <= mag_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          // The last shift lands the result straight into the output
          // registers, so done_o coincides with the DONE state.
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            bcd_o     <= bcd_next;
            seg_o     <= seg_next;
            neg_o     <= neg_reg;
            done_o    <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin_to_7seg.sv
// Scoreboard bench for seq_bin_to_7seg (DATA_W=8, DIGITS=4, signed, active-low).
// The driver pushes expected results computed by decimal arithmetic when a start
// is accepted. A negedge monitor pops them and compares them on each done_o pulse.
module tb_seq_bin_to_7seg;
  localparam int DW = 8;
  localparam int ND = 4;
  localparam logic [6:0] SEG_TBL [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   data;
  logic            sgn;
  logic            blk;
  logic            busy_o;
  logic            done_o;
  logic [4*ND-1:0] bcd_o;
  logic [7*ND-1:0] seg_o;
  logic            neg_o;

  seq_bin_to_7seg #(
    .DATA_W(DW), .DIGITS(ND), .SIGNED_EN(1), .ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
    .signed_i(sgn), .blank_i(blk), .busy_o(busy_o), .done_o(done_o),
    .bcd_o(bcd_o), .seg_o(seg_o), .neg_o(neg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        neg;
    int          done_cyc;
    int          value;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          in_reset = 1'b1;
  logic [15:0] last_bcd = '0;
  logic [27:0] last_seg = '1;
  logic        last_neg = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference: decimal digits by division, blanking from the highest nonzero digit.
  function automatic exp_t model(int unsigned v, bit s, bit b);
    exp_t        e;
    int unsigned mag;
    int unsigned pw;
    int          d[ND];
    int          hi;
    logic [6:0]  p;
    e.neg = s && (v >= 128);
    mag   = e.neg ? 256 - v : v;
    pw    = 1;
    hi    = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = int'((mag / pw) % 10);
      pw   = pw * 10;
      if (d[i] != 0) hi = i;
    end
    e.bcd = '0;
    e.seg = '0;
    for (int i = 0; i < ND; i++) begin
      e.bcd = e.bcd | (16'(d[i]) << (4 * i));
      if (e.neg && i == ND - 1) p = 7'h40;
      else if (b && i > hi)     p = 7'h00;
      else                      p = SEG_TBL[d[i]];
      e.seg = e.seg | (28'(p ^ 7'h7F) << (7 * i));
    end
    e.done_cyc = 0;
    e.value    = int'(v);
    return e;
  endfunction

  // Drive one cycle of inputs (called #1 after a rising edge). A start seen
  // while busy_o is low is accepted at the coming edge.
  task automatic step(bit st, logic [7:0] d, bit s, bit b);
    exp_t e;
    start = st;
    data  = d;
    sgn   = s;
    blk   = b;
    if (st && !busy_o && !rst) begin
      e          = model(int'(d), s, b);
      e.done_cyc = cyc + 1 + DW;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 40) begin
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      n++;
    end
    if (busy_o) chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic convert(logic [7:0] d, bit s, bit b, int gap);
    wait_idle();
    step(1'b1, d, s, b);
    for (int i = 0; i < gap; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Monitor: result check on done_o, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    exp_t e;
    if (!in_reset) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("bcd", 32'(bcd_o), 32'(e.bcd));
          chk("seg", 32'(seg_o), 32'(e.seg));
          chk("neg", 32'(neg_o), 32'(e.neg));
          $display("conv data=%02h bcd=%04h seg=%07h neg=%b", e.value[7:0], bcd_o, seg_o, neg_o);
          last_bcd = e.bcd;
          last_seg = e.seg;
          last_neg = e.neg;
        end
      end else begin
        if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
          chk("done_timeout", 32'(cyc), 32'(sb[0].done_cyc));
          void'(sb.pop_front());
        end
        chk("hold_bcd", 32'(bcd_o), 32'(last_bcd));
        chk("hold_seg", 32'(seg_o), 32'(last_seg));
        chk("hold_neg", 32'(neg_o), 32'(last_neg));
      end
    end
  end

  int perm[256];

  initial begin
    int n;
    int j;
    int t;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    sgn   = 1'b0;
    blk   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bcd",  32'(bcd_o),  32'd0);
    chk("rst_neg",  32'(neg_o),  32'd0);
    chk("rst_seg",  32'(seg_o),  32'h0FFF_FFFF);
    rst = 1'b0;
    in_reset = 1'b0;

    // Directed cases: full-scale, zero with/without blanking, signed extremes.
    convert(8'd255, 1'b0, 1'b0, 1);
    convert(8'd0,   1'b1, 1'b1, 0);
    convert(8'd0,   1'b0, 1'b0, 2);
    convert(8'h80,  1'b1, 1'b0, 0);
    convert(8'hFF,  1'b1, 1'b0, 0);
    convert(8'hFF,  1'b0, 1'b0, 0);
    convert(8'h85,  1'b1, 1'b1, 1);
    convert(8'hF6,  1'b1, 1'b1, 0);
    convert(8'd7,   1'b0, 1'b1, 0);

    // start_i held high with data changing every cycle.
    wait_idle();
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
    step(1'b0, 8'd0, 1'b0, 1'b0);

    // Reset during the fourth shift aborts the conversion.
    wait_idle();
    step(1'b1, 8'd200, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    in_reset = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_bcd",  32'(bcd_o),  32'd0);
    chk("abort_neg",  32'(neg_o),  32'd0);
    chk("abort_seg",  32'(seg_o),  32'h0FFF_FFFF);
    last_bcd = '0;
    last_seg = '1;
    last_neg = 1'b0;
    in_reset = 1'b0;
    convert(8'd201, 1'b0, 1'b1, 0);

    // Every input value once, in random order, random sign/blank modes.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++)
      convert(8'(perm[i]), 1'($urandom), 1'($urandom), int'($urandom_range(2, 0)));

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      step(1'b0, 8'd0, 1'b0, 1'b0);
      n++;
    end
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
